// File: rtl/icache_setassoc_pkg.sv
// rtl/icache_setassoc_pkg.sv - shared types and constants for the set-associative I-cache
//
// Purpose: line geometry, record types for MSHRs, cache ways and per-thread
//          listeners, plus a word-select helper.
// Field widths are sized for the largest supported configuration; the cache
// zero-extends narrower tags/indices into them.
package icache_setassoc_pkg;

    localparam int WORD_W        = 32;
    localparam int LINE_W        = 128;
    localparam int MAX_TAG_W     = 28;
    localparam int MAX_IDX_W     = 8;
    localparam int MAX_MSHR_ID_W = 4;

    typedef struct packed {
        logic                     valid;
        logic [MAX_IDX_W-1:0]     idx;
        logic [MAX_TAG_W-1:0]     tag;
    } icache_mshr_t;

    typedef struct packed {
        logic                     valid;
        logic [MAX_TAG_W-1:0]     tag;
        logic [LINE_W-1:0]        data;
    } icache_way_t;

    typedef struct packed {
        logic                     valid;
        logic [MAX_MSHR_ID_W-1:0] mshr_id;
    } icache_listener_t;

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [1:0] k);
        return line[{k, 5'b0} +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_setassoc_plru.sv
// rtl/icache_setassoc_plru.sv - per-set tree-PLRU state with victim select and two touch ports
//
// Ports: clk, rst (sync, active-high); vic_set -> vic_way (current PLRU victim);
//        t0_* / t1_* touch ports, applied in that order when both hit one set.
// Each tree node bit points toward the less recently used half; touching a
// way points every node on its path away from it. N_WAYS = 1 always yields way 0.
module icache_setassoc_plru #(
    parameter int N_WAYS = 2,
    parameter int N_SETS = 4,
    parameter int IDX_W  = 2,
    parameter int WAY_W  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] vic_set,
    output logic [WAY_W-1:0] vic_way,
    input  logic             t0_en,
    input  logic [IDX_W-1:0] t0_set,
    input  logic [WAY_W-1:0] t0_way,
    input  logic             t1_en,
    input  logic [IDX_W-1:0] t1_set,
    input  logic [WAY_W-1:0] t1_way
);

    localparam int PW = (N_WAYS > 1) ? N_WAYS - 1 : 1;

    function automatic logic [PW-1:0] touch(input logic [PW-1:0] b, input logic [WAY_W-1:0] w);
        logic [PW-1:0] r;
        int node;
        r = b;
        node = 0;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            r[node] = ~w[l];
            node = 2 * node + 1 + int'(w[l]);
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] victim(input logic [PW-1:0] b);
        logic [WAY_W-1:0] v;
        logic dir;
        int node;
        v = '0;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir = b[node];
            v = (v << 1) | WAY_W'(dir);
            node = 2 * node + 1 + int'(dir);
        end
        return v;
    endfunction

    if (N_WAYS == 1) begin : g_direct
        logic unused_ok;
        assign unused_ok = ^{clk, rst, vic_set, t0_en, t0_set, t0_way, t1_en, t1_set, t1_way};
        assign vic_way   = '0;
    end else begin : g_tree
        logic [PW-1:0] bits     [N_SETS];
        logic [PW-1:0] bits_nxt [N_SETS];

        always_comb begin
            for (int s = 0; s < N_SETS; s++) begin
                bits_nxt[s] = bits[s];
                if (t0_en && t0_set == IDX_W'(s)) bits_nxt[s] = touch(bits_nxt[s], t0_way);
                if (t1_en && t1_set == IDX_W'(s)) bits_nxt[s] = touch(bits_nxt[s], t1_way);
            end
        end

        always_ff @(posedge clk) begin
            for (int s = 0; s < N_SETS; s++) begin
                if (rst) bits[s] <= '0;
                else     bits[s] <= bits_nxt[s];
            end
        end

        assign vic_way = victim(bits[vic_set]);
    end

endmodule

// File: rtl/icache_setassoc.sv
// rtl/icache_setassoc.sv - N-way set-associative I-cache with MSHRs and per-thread stall bits
//
// Ports: clk, rst (sync, active-high); lookup thread/paddr/itlb_miss -> miss/data
//        (registered, 1-cycle latency); memory request mem_req_ren/addr/ready;
//        fill mem_rec_en/addr/cacheline; per-thread stalled bits.
// Optional: define ICACHE_PERF_EN for perf_hits / perf_misses counters.
module icache_setassoc #(
    parameter int N_WAYS    = 2,
    parameter int N_SETS    = 4,
    parameter int N_MSHR    = 2,
    parameter int N_THREADS = 2,
    parameter int ADDR_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [((N_THREADS > 1) ? $clog2(N_THREADS) : 1)-1:0] thread,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic                  itlb_miss,
    output logic                  miss,
    output logic [31:0]           data,
    output logic                  mem_req_ren,
    output logic [ADDR_W-1:0]     mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_rec_en,
    input  logic [ADDR_W-1:0]     mem_rec_addr,
    input  logic [127:0]          mem_rec_cacheline,
`ifdef ICACHE_PERF_EN
    output logic [31:0]           perf_hits,
    output logic [31:0]           perf_misses,
`endif
    output logic [N_THREADS-1:0]  stalled
);
    import icache_setassoc_pkg::*;

    localparam int IDX_W = (N_SETS > 1) ? $clog2(N_SETS) : 1;
    localparam int WAY_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
    localparam int MID_W = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;
    localparam int TAG_W = ADDR_W - 4 - IDX_W;

    icache_way_t      ways [N_SETS][N_WAYS];
    icache_mshr_t     mshr [N_MSHR];
    icache_listener_t lsn  [N_THREADS];

    logic [IDX_W-1:0]     req_idx, fill_idx;
    logic [MAX_TAG_W-1:0] req_tag, fill_tag;
    logic [WAY_W-1:0]     plru_vic, fill_way, hit_way, touch_way;
    logic [MID_W-1:0]     fill_id, pend_id, free_id;
    logic                 fill_hit, way_hit, bypass, pend_hit, free_any, found_inv;
    logic                 do_lookup, hit, lookup_miss, slot_idle, attach, alloc;
    logic [31:0]          hit_word;
    logic                 unused_ok;

    assign req_idx   = paddr[4 +: IDX_W];
    assign fill_idx  = mem_rec_addr[4 +: IDX_W];
    assign req_tag   = MAX_TAG_W'(paddr[ADDR_W-1 -: TAG_W]);
    assign fill_tag  = MAX_TAG_W'(mem_rec_addr[ADDR_W-1 -: TAG_W]);
    assign unused_ok = ^{paddr[1:0], mem_rec_addr[3:0]};

    icache_setassoc_plru #(.N_WAYS(N_WAYS), .N_SETS(N_SETS), .IDX_W(IDX_W), .WAY_W(WAY_W)) u_plru (
        .clk(clk), .rst(rst),
        .vic_set(fill_idx), .vic_way(plru_vic),
        .t0_en(fill_hit), .t0_set(fill_idx), .t0_way(fill_way),
        .t1_en(hit),      .t1_set(req_idx),  .t1_way(touch_way)
    );

    always_comb begin
        fill_hit  = 1'b0;
        fill_id   = '0;
        for (int m = 0; m < N_MSHR; m++) begin
            if (mem_rec_en && mshr[m].valid && mshr[m].idx == MAX_IDX_W'(fill_idx)
                && mshr[m].tag == fill_tag) begin
                fill_hit = 1'b1;
                fill_id  = MID_W'(m);
            end
        end
        // Lowest invalid way beats the PLRU choice.
        fill_way  = plru_vic;
        found_inv = 1'b0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (!ways[fill_idx][w].valid && !found_inv) begin
                fill_way  = WAY_W'(w);
                found_inv = 1'b1;
            end
        end

        do_lookup = !itlb_miss && !stalled[thread];
        // Fill is applied first: a way being overwritten this cycle no longer
        // holds its old line, and the incoming line is served via the bypass.
        way_hit = 1'b0;
        hit_way = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (ways[req_idx][w].valid && ways[req_idx][w].tag == req_tag
                && !(fill_hit && fill_idx == req_idx && fill_way == WAY_W'(w))) begin
                way_hit = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        bypass    = fill_hit && fill_idx == req_idx && fill_tag == req_tag;
        hit       = do_lookup && (way_hit || bypass);
        touch_way = bypass ? fill_way : hit_way;
        hit_word  = bypass ? line_word(mem_rec_cacheline, paddr[3:2])
                           : line_word(ways[req_idx][hit_way].data, paddr[3:2]);

        pend_hit = 1'b0;
        pend_id  = '0;
        free_any = 1'b0;
        free_id  = '0;
        for (int m = N_MSHR - 1; m >= 0; m--) begin
            if (mshr[m].valid && mshr[m].idx == MAX_IDX_W'(req_idx) && mshr[m].tag == req_tag) begin
                pend_hit = 1'b1;
                pend_id  = MID_W'(m);
            end
            // An MSHR released by this cycle's fill is immediately reusable.
            if (!mshr[m].valid || (fill_hit && fill_id == MID_W'(m))) begin
                free_any = 1'b1;
                free_id  = MID_W'(m);
            end
        end
        lookup_miss = do_lookup && !hit;
        slot_idle   = !mem_req_ren || mem_req_ready;
        alloc       = lookup_miss && !pend_hit && free_any && slot_idle;
        attach      = lookup_miss && (pend_hit || (free_any && slot_idle));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N_SETS; s++)
                for (int w = 0; w < N_WAYS; w++)
                    ways[s][w].valid <= 1'b0;
            for (int m = 0; m < N_MSHR; m++) mshr[m].valid <= 1'b0;
            for (int t = 0; t < N_THREADS; t++) lsn[t].valid <= 1'b0;
            stalled      <= '0;
            miss         <= 1'b0;
            data         <= '0;
            mem_req_ren  <= 1'b0;
            mem_req_addr <= '0;
        end else begin
            if (fill_hit) begin
                ways[fill_idx][fill_way].valid <= 1'b1;
                ways[fill_idx][fill_way].tag   <= fill_tag;
                ways[fill_idx][fill_way].data  <= mem_rec_cacheline;
                mshr[fill_id].valid            <= 1'b0;
                for (int t = 0; t < N_THREADS; t++) begin
                    if (lsn[t].valid && lsn[t].mshr_id == MAX_MSHR_ID_W'(fill_id)) begin
                        lsn[t].valid <= 1'b0;
                        stalled[t]   <= 1'b0;
                    end
                end
            end
            if (alloc) begin
                mshr[free_id].valid <= 1'b1;
                mshr[free_id].idx   <= MAX_IDX_W'(req_idx);
                mshr[free_id].tag   <= req_tag;
            end
            if (attach) begin
                lsn[thread].valid   <= 1'b1;
                lsn[thread].mshr_id <= MAX_MSHR_ID_W'(pend_hit ? pend_id : free_id);
                stalled[thread]     <= 1'b1;
            end
            if (alloc) begin
                mem_req_ren  <= 1'b1;
                mem_req_addr <= {paddr[ADDR_W-1:4], 4'h0};
            end else if (mem_req_ready) begin
                mem_req_ren  <= 1'b0;
            end
            miss <= lookup_miss;
            if (hit) data <= hit_word;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else begin
            if (hit)         perf_hits   <= perf_hits + 32'd1;
            if (lookup_miss) perf_misses <= perf_misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_setassoc.sv
// tb/tb_icache_setassoc.sv - scoreboard bench for icache_setassoc with a behavioural cache model
module tb_icache_setassoc;
    localparam int NW = 2, NS = 4, NM = 2, NT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   thread = '0;
    logic [31:0]  paddr = '0;
    logic         itlb_miss = 1'b1;
    logic         miss;
    logic [31:0]  data;
    logic         mem_req_ren;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready = 1'b0;
    logic         mem_rec_en = 1'b0;
    logic [31:0]  mem_rec_addr = '0;
    logic [127:0] mem_rec_cacheline = '0;
    logic [NT-1:0] stalled;
`ifdef ICACHE_PERF_EN
    logic [31:0]  perf_hits, perf_misses;
`endif

    always #5 clk = ~clk;

    icache_setassoc #(.N_WAYS(NW), .N_SETS(NS), .N_MSHR(NM), .N_THREADS(NT), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .thread(thread), .paddr(paddr), .itlb_miss(itlb_miss),
        .miss(miss), .data(data), .mem_req_ren(mem_req_ren), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready), .mem_rec_en(mem_rec_en), .mem_rec_addr(mem_rec_addr),
        .mem_rec_cacheline(mem_rec_cacheline),
`ifdef ICACHE_PERF_EN
        .perf_hits(perf_hits), .perf_misses(perf_misses),
`endif
        .stalled(stalled)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] line_data(input logic [31:0] la);
        logic [127:0] d;
        for (int k = 0; k < 4; k++)
            d[32*k +: 32] = (la * 32'h9E3779B1) ^ (32'(k) * 32'h1111_1111 + 32'h0BAD_F00D);
        return d;
    endfunction

    function automatic int set_of(input logic [31:0] la);
        return int'((la >> 4) % NS);
    endfunction

    typedef struct {
        logic          miss;
        logic [31:0]   data;
        logic [NT-1:0] stalled;
        logic          ren;
        logic [31:0]   addr;
    } exp_t;
    exp_t sb[$];

    // Reference model: cache as per-set slots of line addresses with LRU
    // timestamps (tree-PLRU equals true LRU at 2 ways), pending-line table,
    // per-thread waiters and the single outstanding request.
    bit          cv    [NS][NW];
    logic [31:0] cline [NS][NW];
    int          cuse  [NS][NW];
    int          tick = 0;
    bit          mv    [NM];
    logic [31:0] mline [NM];
    bit          lv    [NT];
    int          lid   [NT];
    logic [NT-1:0] stl = '0;
    bit          rv = 0;
    logic [31:0] raddr_m = '0;
    logic        exp_miss = 0;
    logic [31:0] exp_data = '0;
    logic [31:0] memq[$];

    task automatic step(input bit r, input int thr, input logic [31:0] pa, input bit itlb,
                        input bit rdy, input bit fen, input logic [31:0] fa);
        exp_t e;
        logic [NT-1:0] stl0;
        logic [31:0] la, fl;
        logic [127:0] ld;
        int st, vw, fm, pm, freem;
        bit hit, new_alloc;
        @(negedge clk);
        fl = fa & ~32'hF;
        rst = r; thread = thr[1:0]; paddr = pa; itlb_miss = itlb;
        mem_req_ready = rdy; mem_rec_en = fen; mem_rec_addr = fa;
        mem_rec_cacheline = line_data(fl);
        if (r) begin
            for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) cv[s][w] = 0;
            for (int m = 0; m < NM; m++) mv[m] = 0;
            for (int t = 0; t < NT; t++) lv[t] = 0;
            stl = '0; rv = 0; raddr_m = '0; exp_miss = 0; exp_data = '0;
        end else begin
            stl0 = stl;
            fm = -1;
            if (fen) for (int m = 0; m < NM; m++) if (mv[m] && mline[m] == fl) fm = m;
            if (fm >= 0) begin
                st = set_of(fl);
                vw = -1;
                for (int w = 0; w < NW; w++) if (!cv[st][w] && vw < 0) vw = w;
                if (vw < 0) begin
                    vw = 0;
                    for (int w = 1; w < NW; w++) if (cuse[st][w] < cuse[st][vw]) vw = w;
                end
                cv[st][vw] = 1; cline[st][vw] = fl; cuse[st][vw] = ++tick;
                mv[fm] = 0;
                for (int t = 0; t < NT; t++) if (lv[t] && lid[t] == fm) begin lv[t] = 0; stl[t] = 0; end
            end
            if (rv && rdy) memq.push_back(raddr_m);
            exp_miss = 0;
            new_alloc = 0;
            if (!itlb && !stl0[thr]) begin
                la = pa & ~32'hF;
                st = set_of(la);
                hit = 0;
                for (int w = 0; w < NW; w++) if (cv[st][w] && cline[st][w] == la) begin
                    hit = 1; cuse[st][w] = ++tick;
                end
                if (hit) begin
                    ld = line_data(la);
                    exp_data = ld[32*pa[3:2] +: 32];
                end else begin
                    exp_miss = 1;
                    pm = -1; freem = -1;
                    for (int m = 0; m < NM; m++) if (mv[m] && mline[m] == la) pm = m;
                    for (int m = NM - 1; m >= 0; m--) if (!mv[m]) freem = m;
                    if (pm >= 0) begin
                        lv[thr] = 1; lid[thr] = pm; stl[thr] = 1;
                    end else if (freem >= 0 && (!rv || rdy)) begin
                        mv[freem] = 1; mline[freem] = la;
                        lv[thr] = 1; lid[thr] = freem; stl[thr] = 1;
                        rv = 1; raddr_m = la; new_alloc = 1;
                    end
                end
            end
            if (!new_alloc && rv && rdy) rv = 0;
        end
        e = '{exp_miss, exp_data, stl, rv, raddr_m};
        sb.push_back(e);
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 32'h0, 1, rdy, 0, 32'h0);
    endtask

    task automatic fill(input logic [31:0] fa);
        step(0, 0, 32'h0, 1, 1, 1, fa);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge produces one registered response; compare it to the
    // expectation queued when that cycle's stimulus was issued.
    exp_t me;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            me = sb.pop_front();
            chk("miss", miss, me.miss);
            chk("data", data, me.data);
            chk("stalled", stalled, me.stalled);
            chk("mem_req_ren", mem_req_ren, me.ren);
            chk("mem_req_addr", mem_req_addr, me.addr);
        end
    end

    logic [127:0] ld_tb;

    initial begin
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        settle();
        chk("reset_stalled", stalled, 0);
        chk("reset_ren", mem_req_ren, 0);

        // Cold miss then fill
        step(0, 0, 32'h104, 0, 1, 0, 0);
        settle();
        chk("cold_miss", miss, 1);
        chk("cold_stall", stalled, 4'b0001);
        chk("cold_req_addr", mem_req_addr, 32'h100);
        idle(1);
        fill(32'h100);
        settle();
        chk("cold_unstall", stalled, 0);
        step(0, 0, 32'h104, 0, 1, 0, 0);
        settle();
        ld_tb = line_data(32'h100);
        chk("cold_rehit_miss", miss, 0);
        chk("cold_rehit_data", data, ld_tb[63:32]);

        // Shared MSHR
        step(0, 0, 32'h200, 0, 0, 0, 0);
        step(0, 1, 32'h200, 0, 0, 0, 0);
        settle();
        chk("shared_stall", stalled, 4'b0011);
        idle(1);
        idle(1);
        settle();
        chk("shared_single_req", mem_req_ren, 0);
        fill(32'h200);
        settle();
        chk("shared_unstall", stalled, 0);

        // MSHR exhaustion
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 32'h100, 0, 1, 0, 0);
        step(0, 1, 32'h300, 0, 1, 0, 0);
        step(0, 2, 32'h500, 0, 1, 0, 0);
        settle();
        chk("exhaust_miss", miss, 1);
        chk("exhaust_stall", stalled, 4'b0011);
        chk("exhaust_noreq", mem_req_ren, 0);
        fill(32'h100);
        step(0, 2, 32'h500, 0, 0, 0, 0);
        settle();
        chk("exhaust_retry_stall", stalled, 4'b0110);
        chk("exhaust_retry_addr", mem_req_addr, 32'h500);
        idle(1);
        fill(32'h300);
        fill(32'h500);

        // Replacement within one set
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 32'h000, 0, 1, 0, 0); idle(1); fill(32'h000);
        step(0, 0, 32'h040, 0, 1, 0, 0); idle(1); fill(32'h040);
        step(0, 0, 32'h000, 0, 1, 0, 0);
        step(0, 0, 32'h080, 0, 1, 0, 0); idle(1); fill(32'h080);
        step(0, 1, 32'h004, 0, 1, 0, 0);
        settle();
        chk("repl_keep_hit", miss, 0);
        step(0, 0, 32'h044, 0, 1, 0, 0);
        settle();
        chk("repl_evicted_miss", miss, 1);

        // Same-cycle fill bypass and stray fill
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 32'h100, 0, 1, 0, 0);
        idle(1);
        step(0, 1, 32'h108, 0, 1, 1, 32'h100);
        settle();
        ld_tb = line_data(32'h100);
        chk("bypass_miss", miss, 0);
        chk("bypass_data", data, ld_tb[95:64]);
        fill(32'h900);
        step(0, 1, 32'h904, 0, 1, 0, 0);
        settle();
        chk("stray_ignored", miss, 1);

        // Reset while a request is held
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 32'h700, 0, 0, 0, 0);
        settle();
        chk("held_ren", mem_req_ren, 1);
        step(1, 0, 0, 1, 0, 0, 0);
        settle();
        chk("rst_ren", mem_req_ren, 0);
        chk("rst_stalled", stalled, 0);
        fill(32'h700);
        step(0, 1, 32'h700, 0, 0, 0, 0);
        settle();
        chk("late_fill_ignored", miss, 1);

        // Randomised traffic; memory returns accepted lines after a random delay
        memq.delete();
        for (int i = 0; i < 3000; i++) begin
            bit r, it, rd, fe;
            logic [31:0] pa, fa;
            r  = ($urandom_range(0, 299) == 0);
            pa = (32'($urandom_range(0, 23)) << 4) | 32'($urandom_range(0, 15));
            it = ($urandom_range(0, 9) == 0);
            rd = ($urandom_range(0, 9) < 7);
            fe = 0;
            fa = '0;
            if (memq.size() > 0 && $urandom_range(0, 1) == 1) begin
                fe = 1; fa = memq.pop_front();
            end else if ($urandom_range(0, 19) == 0) begin
                fe = 1; fa = 32'($urandom_range(0, 23)) << 4;
            end
            step(r, int'($urandom_range(0, NT - 1)), pa, it, rd, fe, fa);
        end
        idle(0);
        idle(0);
        settle();
        settle();
        chk("scoreboard_drained", 128'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
